// File: rtl/row_position_counter_pkg.sv
// -----------------------------------------------------------------------------
// row_position_counter_pkg
//
// Shared definitions for the playfield movement blocks. The direction
// controller, the row counter and the column counter all import this package
// so they agree on the layout of the 2-bit direction word and on the encoding
// of the bound-tracking FSM.
//
// Contents:
//   DIR_EN_BIT   - bit of the direction word that enables movement
//   DIR_UP_BIT   - bit of the direction word selecting increment (1) / decrement (0)
//   pos_state_t  - bound-tracking FSM state encoding
//   state_for()  - maps "at lowest bound" / "at highest bound" flags to a state
// -----------------------------------------------------------------------------
package row_position_counter_pkg;

    localparam int DIR_EN_BIT = 0;
    localparam int DIR_UP_BIT = 1;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_AT_TOP    = 2'd1,
        ST_AT_BOTTOM = 2'd2
    } pos_state_t;

    // The bottom bound wins when both flags are set, which only happens in the
    // degenerate single-row playfield.
    function automatic pos_state_t state_for(input logic is_bottom, input logic is_top);
        pos_state_t s;
        if (is_bottom) begin
            s = ST_AT_BOTTOM;
        end else if (is_top) begin
            s = ST_AT_TOP;
        end else begin
            s = ST_FREE;
        end
        return s;
    endfunction

endpackage

// File: rtl/row_position_counter_if.sv
// -----------------------------------------------------------------------------
// row_position_counter_if
//
// Bundles the direction/pause inputs and the position/status outputs of the
// row counter.
//
// Signal contract: there is no valid/ready handshake. dir_in and freeze are
// level signals owned by the master; dir_in is only looked at on a step tick,
// freeze is looked at every cycle. All slave outputs are registered and are
// valid every cycle; step_tick and edge_hit are single-cycle pulses.
//
// Signals:
//   dir_in    (master -> slave) bit 0 enable, bit 1 up/down
//   freeze    (master -> slave) pause prescaler and position
//   y_pos     (slave -> master) current row
//   step_tick (slave -> master) one-cycle pulse per step boundary
//   at_top    (slave -> master) row is at the highest legal value
//   at_bottom (slave -> master) row is 0
//   edge_hit  (slave -> master) one-cycle pulse when a clamped step is blocked
// -----------------------------------------------------------------------------
interface row_position_counter_if #(
    parameter int Y_W = 9
);
    logic [1:0]     dir_in;
    logic           freeze;
    logic [Y_W-1:0] y_pos;
    logic           step_tick;
    logic           at_top;
    logic           at_bottom;
    logic           edge_hit;

    modport master (
        output dir_in,
        output freeze,
        input  y_pos,
        input  step_tick,
        input  at_top,
        input  at_bottom,
        input  edge_hit
    );

    modport slave (
        input  dir_in,
        input  freeze,
        output y_pos,
        output step_tick,
        output at_top,
        output at_bottom,
        output edge_hit
    );
endinterface

// File: rtl/row_position_counter_step_prescaler.sv
// -----------------------------------------------------------------------------
// step_prescaler
//
// Divides the system clock down to the movement rate. cnt runs 0..STEP_DIV-1;
// tick is high in the cycle cnt sits at STEP_DIV-1 with freeze low, and cnt
// wraps to 0 on that edge. With freeze high cnt holds, so a tick that would
// have fired is deferred to the first unfrozen cycle.
//
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset, clears cnt
//   freeze in  hold the count and suppress tick
//   tick   out combinational step strobe, decoded from cnt and freeze
// -----------------------------------------------------------------------------
module step_prescaler #(
    parameter int STEP_DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    output logic tick
);
    localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST) && !freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!freeze) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/row_position_counter.sv
// -----------------------------------------------------------------------------
// row_position_counter
//
// Tracks the vertical position of the moving object. Every STEP_DIV unfrozen
// cycles the direction word is sampled and the row moves by one, clamped at
// (WRAP=0) or wrapped around (WRAP=1) the playfield bounds 0..Y_MAX. A small
// Moore FSM records whether the row sits on a bound and drives at_top /
// at_bottom.
//
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   bus       slave modport of row_position_counter_if (dir_in, freeze in;
//             y_pos, step_tick, at_top, at_bottom, edge_hit out)
//   state_dbg out current bound-tracking FSM state
// -----------------------------------------------------------------------------
module row_position_counter
    import row_position_counter_pkg::*;
#(
    parameter int Y_W      = 9,
    parameter int Y_MAX    = 479,
    parameter int Y_INIT   = 240,
    parameter int STEP_DIV = 250000,
    parameter bit WRAP     = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    row_position_counter_if.slave        bus,
    output pos_state_t                   state_dbg
);
    localparam logic [Y_W-1:0] Y_TOP   = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0] Y_START = Y_W'(Y_INIT);

    logic           tick;
    logic           en;
    logic           up;
    logic [Y_W-1:0] y_q;
    logic [Y_W-1:0] y_next;
    logic           blocked;
    logic           step_tick_q;
    logic           edge_hit_q;
    pos_state_t     state_q;
    pos_state_t     state_next;

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_step_prescaler (
        .clk    (clk),
        .rst    (rst),
        .freeze (bus.freeze),
        .tick   (tick)
    );

    assign en = bus.dir_in[DIR_EN_BIT];
    assign up = bus.dir_in[DIR_UP_BIT];

    // Bounds are checked before any add/subtract, so the arithmetic never
    // leaves 0..Y_MAX and never wraps through the Y_W-bit range.
    always_comb begin
        y_next  = y_q;
        blocked = 1'b0;
        if (tick && en) begin
            if (up) begin
                if (y_q == Y_TOP) begin
                    if (WRAP) begin
                        y_next = '0;
                    end else begin
                        blocked = 1'b1;
                    end
                end else begin
                    y_next = y_q + 1'b1;
                end
            end else begin
                if (y_q == '0) begin
                    if (WRAP) begin
                        y_next = Y_TOP;
                    end else begin
                        blocked = 1'b1;
                    end
                end else begin
                    y_next = y_q - 1'b1;
                end
            end
        end
    end

    // FSM next state follows the row value being written this cycle, so the
    // state and y_pos always change on the same edge.
    always_comb begin
        state_next = state_q;
        state_next = state_for(y_next == '0, y_next == Y_TOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= state_for(Y_START == '0, Y_START == Y_TOP);
        end else begin
            state_q <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= Y_START;
            step_tick_q <= 1'b0;
            edge_hit_q  <= 1'b0;
        end else begin
            y_q         <= y_next;
            step_tick_q <= tick;
            edge_hit_q  <= blocked;
        end
    end

    assign bus.y_pos     = y_q;
    assign bus.step_tick = step_tick_q;
    assign bus.edge_hit  = edge_hit_q;
    assign bus.at_top    = (state_q == ST_AT_TOP);
    assign bus.at_bottom = (state_q == ST_AT_BOTTOM);
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_row_position_counter.sv
// -----------------------------------------------------------------------------
// tb_row_position_counter
//
// Two instances with STEP_DIV=4, Y_MAX=7, Y_INIT=3: dut0 clamps (WRAP=0),
// dut1 wraps (WRAP=1). Both receive the same stimulus. Expected tick results
// are queued when a step is commanded and popped when step_tick is seen.
// -----------------------------------------------------------------------------
module tb_row_position_counter;
    import row_position_counter_pkg::*;

    localparam int STEP_DIV = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    row_position_counter_if #(.Y_W(9)) if0 ();
    row_position_counter_if #(.Y_W(9)) if1 ();
    pos_state_t sd0;
    pos_state_t sd1;

    row_position_counter #(
        .Y_W(9), .Y_MAX(7), .Y_INIT(3), .STEP_DIV(STEP_DIV), .WRAP(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .state_dbg(sd0)
    );

    row_position_counter #(
        .Y_W(9), .Y_MAX(7), .Y_INIT(3), .STEP_DIV(STEP_DIV), .WRAP(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .state_dbg(sd1)
    );

    // scoreboard
    logic [14:0] exp_q0[$];
    logic [14:0] exp_q1[$];
    int vectors = 0;
    int miscompares = 0;
    logic [8:0] y0 = 9'd3;
    logic [8:0] y1 = 9'd3;

    // reference model
    function automatic logic [8:0] next_y(input logic [8:0] y, input logic [1:0] dir, input bit wrap);
        logic [8:0] r;
        r = y;
        if (dir[0]) begin
            if (dir[1]) begin
                if (y == 9'd7) r = wrap ? 9'd0 : 9'd7;
                else           r = y + 9'd1;
            end else begin
                if (y == 9'd0) r = wrap ? 9'd7 : 9'd0;
                else           r = y - 9'd1;
            end
        end
        return r;
    endfunction

    function automatic logic is_blocked(input logic [8:0] y, input logic [1:0] dir, input bit wrap);
        return dir[0] && !wrap && ((dir[1] && y == 9'd7) || (!dir[1] && y == 9'd0));
    endfunction

    // {step_tick, state, edge_hit, at_bottom, at_top, y_pos}
    function automatic logic [14:0] pack_exp(input logic tk, input logic [8:0] y, input logic e);
        logic [1:0] st;
        if (y == 9'd0)      st = 2'd2;
        else if (y == 9'd7) st = 2'd1;
        else                st = 2'd0;
        return {tk, st, e, (y == 9'd0), (y == 9'd7), y};
    endfunction

    function automatic logic [14:0] obs0();
        return {if0.step_tick, sd0, if0.edge_hit, if0.at_bottom, if0.at_top, if0.y_pos};
    endfunction

    function automatic logic [14:0] obs1();
        return {if1.step_tick, sd1, if1.edge_hit, if1.at_bottom, if1.at_top, if1.y_pos};
    endfunction

    // driver / checker tasks
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_dir(input logic [1:0] dir);
        if0.dir_in = dir;
        if1.dir_in = dir;
    endtask

    task automatic drive_freeze(input logic f);
        if0.freeze = f;
        if1.freeze = f;
    endtask

    // Between ticks: no pulses and the row must not move.
    task automatic check_quiet(input string tag);
        check({tag, "_quiet0"}, {5'd0, if0.step_tick, if0.edge_hit, if0.y_pos}, {5'd0, 2'b00, y0});
        check({tag, "_quiet1"}, {5'd0, if1.step_tick, if1.edge_hit, if1.y_pos}, {5'd0, 2'b00, y1});
    endtask

    task automatic push_step(input logic [1:0] dir);
        exp_q0.push_back(pack_exp(1'b1, next_y(y0, dir, 1'b0), is_blocked(y0, dir, 1'b0)));
        exp_q1.push_back(pack_exp(1'b1, next_y(y1, dir, 1'b1), is_blocked(y1, dir, 1'b1)));
    endtask

    task automatic check_tick(input string tag);
        logic [14:0] e;
        if (exp_q0.size() == 0) begin
            check({tag, "_q0_empty"}, 16'(exp_q0.size()), 16'd1);
        end else begin
            e = exp_q0.pop_front();
            check({tag, "_tick0"}, {1'b0, obs0()}, {1'b0, e});
            y0 = e[8:0];
        end
        if (exp_q1.size() == 0) begin
            check({tag, "_q1_empty"}, 16'(exp_q1.size()), 16'd1);
        end else begin
            e = exp_q1.pop_front();
            check({tag, "_tick1"}, {1'b0, obs1()}, {1'b0, e});
            y1 = e[8:0];
        end
    endtask

    // Called right after a tick (cnt == 0). The inverted word is held until
    // the cycle before the tick to show only the tick-cycle value matters.
    task automatic do_step(input string tag, input logic [1:0] dir);
        push_step(dir);
        drive_dir(~dir);
        for (int i = 1; i < STEP_DIV; i++) begin
            @(negedge clk);
            check_quiet(tag);
            if (i == STEP_DIV - 1) drive_dir(dir);
        end
        @(negedge clk);
        check_tick(tag);
    endtask

    initial begin
        drive_dir(2'b11);
        drive_freeze(1'b0);

        // reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset0", {1'b0, obs0()}, {1'b0, pack_exp(1'b0, 9'd3, 1'b0)});
        check("reset1", {1'b0, obs1()}, {1'b0, pack_exp(1'b0, 9'd3, 1'b0)});
        rst = 1'b0;

        // climb to the top bound
        for (int i = 0; i < 4; i++) do_step("up", 2'b11);
        // blocked (clamp) / wrap to 0, then again
        do_step("up_top", 2'b11);
        do_step("up_top2", 2'b11);
        // descend: wrap instance goes 1 -> 0 -> 7
        do_step("down", 2'b10);
        do_step("down_wrap", 2'b10);
        // disabled: ticks continue, row holds
        for (int i = 0; i < 5; i++) do_step("hold", 2'b00);
        // clamp instance reaches 0 and gets blocked twice
        for (int i = 0; i < 7; i++) do_step("down_bot", 2'b10);

        // freeze asserted on the cnt == STEP_DIV-1 cycle for 6 cycles
        push_step(2'b11);
        drive_dir(2'b11);
        for (int i = 1; i < STEP_DIV; i++) begin
            @(negedge clk);
            check_quiet("pre_freeze");
        end
        drive_freeze(1'b1);
        repeat (6) begin
            @(negedge clk);
            check_quiet("frozen");
        end
        drive_freeze(1'b0);
        @(negedge clk);
        check_tick("unfreeze");

        // reset on a tick cycle
        drive_dir(2'b11);
        for (int i = 1; i < STEP_DIV; i++) begin
            @(negedge clk);
            check_quiet("pre_rst");
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_tick0", {1'b0, obs0()}, {1'b0, pack_exp(1'b0, 9'd3, 1'b0)});
        check("rst_tick1", {1'b0, obs1()}, {1'b0, pack_exp(1'b0, 9'd3, 1'b0)});
        rst = 1'b0;
        y0 = 9'd3;
        y1 = 9'd3;
        do_step("after_rst", 2'b11);

        // one period with no step pending: nothing may fire
        drive_dir(2'b11);
        for (int i = 1; i < STEP_DIV; i++) begin
            @(negedge clk);
            check_quiet("tail");
        end

        check("leftover_q0", 16'(exp_q0.size()), 16'd0);
        check("leftover_q1", 16'(exp_q1.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
